meta_deparser_emitter: RTL and testbench
========================================

// Module: meta_deparser_emitter
// PURPOSE
// Transmit-side counterpart of the parser capture buffer. Accepts a parsed/modified
// header buffer (big-endian, beat 0 in the MSBs) and serialises it onto AXI-Stream,
// byte-reversing each beat back to wire order, then forwards the remaining payload.
// Sits between the match/action stage and the output packet dispatcher.
// PARAMETERS
// AXIS_DATA_WIDTH      64                        stream data width, multiple of 8
// AXIS_KEEP_WIDTH      AXIS_DATA_WIDTH/8         tkeep width
// AXIS_DEST_WIDTH      2                         tdest width
// COUNT_META_DATA_MAX  5                         max header beats held in buffer
// COUNTER_WIDTH        $clog2(COUNT_META_DATA_MAX+1)  beat counter width
// BUFFER_DATA_WIDTH    COUNT_META_DATA_MAX*AXIS_DATA_WIDTH  header buffer width
// PORTS
// clk            in   1                  clock
// rst            in   1                  asynchronous active-high reset
// hdr_data       in   BUFFER_DATA_WIDTH  header buffer, beat k = [BDW-1-k*W -: W]
// hdr_count      in   COUNTER_WIDTH      header beats to emit, 1..COUNT_META_DATA_MAX
// hdr_dest       in   AXIS_DEST_WIDTH    output tdest for whole packet
// hdr_drop       in   1                  discard packet (emit nothing, drain payload)
// hdr_last       in   1                  packet ends on last header beat (no payload)
// hdr_valid      in   1                  header descriptor valid
// hdr_ready      out  1                  descriptor accepted when valid&&ready
// s_axis_tdata   in   AXIS_DATA_WIDTH    payload beats after header (wire byte order)
// s_axis_tkeep   in   AXIS_KEEP_WIDTH    payload byte enables
// s_axis_tvalid  in   1                  payload valid
// s_axis_tready  out  1                  payload ready
// s_axis_tlast   in   1                  payload last
// m_axis_tdata   out  AXIS_DATA_WIDTH    output data
// m_axis_tkeep   out  AXIS_KEEP_WIDTH    output byte enables
// m_axis_tvalid  out  1                  output valid
// m_axis_tready  in   1                  output ready
// m_axis_tlast   out  1                  output last
// m_axis_tdest   out  AXIS_DEST_WIDTH    output destination
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE; hdr_ready=0 during reset, s_axis_tready=0,
//   m_axis_tvalid=0, tdata/tkeep/tlast/tdest=0, beat counter=0. Mid-packet reset
//   abandons packet; no partial beat is presented after release.
// - Output is a single register stage; it may load when !m_axis_tvalid || m_axis_tready.
// - IDLE: hdr_ready=1. On accept: latch hdr_data/count/dest/last/drop, cnt=0;
//   drop -> DROP, else -> SEND_HEADER. hdr_count=0 treated as 1.
// - SEND_HEADER: each load puts reverse_bytes(buf beat cnt) on tdata, tkeep=all ones,
//   tdest=latched dest, cnt++. First header beat visible m_axis_tvalid the cycle after
//   descriptor accept (latency 1). On loading beat hdr_count-1: tlast=hdr_last;
//   hdr_last -> IDLE, else -> SEND_PAYLOAD. s_axis_tready=0 throughout.
// - SEND_PAYLOAD: s_axis_tready = !m_axis_tvalid || m_axis_tready; each s beat is
//   registered unchanged (tdata, tkeep, tlast) with latched tdest. Beat with
//   s_axis_tlast accepted -> IDLE. No bubbles between last header and payload when
//   both sides ready.
// - IDLE is re-entered while final beat may still be in the output register; next
//   descriptor may be accepted then, its first beat loads only once that beat drains.
// - DROP: m_axis_tvalid stays 0 for this packet; s_axis_tready=1; accept until tlast
//   -> IDLE. Pending output beat from previous packet still drains normally.
// - Backpressure: m_axis_tready=0 holds tdata/tkeep/tlast/tdest/tvalid stable; cnt
//   does not advance.
// - Byte reversal: out[i*8+:8] = beat[(NB-1-i)*8+:8], NB=AXIS_KEEP_WIDTH.
// TESTING
// 1 hdr_count=2, hdr_data beat0=0x0011223344556677, beat1=0x8899AABBCCDDEEFF,
//   hdr_last=0, 1-beat payload tlast -> out 0x7766554433221100, 0xFFEEDDCCBBAA9988,
//   payload; tlast only on payload; first tvalid 1 cycle after accept.
// 2 hdr_count=3, hdr_last=1 -> exactly 3 beats, tkeep=0xFF, tlast on 3rd, s_axis_tready=0.
// 3 hdr_drop=1, 4 payload beats -> no m_axis_tvalid, s_axis_tready=1 all 4, back to IDLE.
// 4 m_axis_tready toggled 1/0 randomly over 5-beat header + 3-beat payload -> output
//   sequence identical to tready=1 run, data stable while stalled.
// 5 Back-to-back descriptors, tready=1 -> zero idle cycles beyond 1-cycle accept
//   latency per packet; tdest switches exactly on first beat of packet 2.
// 6 Assert rst while in SEND_PAYLOAD -> m_axis_tvalid=0 immediately; after release
//   new packet emits correctly from beat 0.

Source files
------------

// File: rtl/meta_deparser_emitter.sv
// Serialises a parsed header buffer onto AXI-Stream (byte-reversed to wire order), then forwards payload.
// Latency: first header beat on m_axis one cycle after descriptor accept; payload beats pass through one register stage.
// Backpressure: single output register loads when !m_axis_tvalid || m_axis_tready; s_axis_tready follows that in SEND_PAYLOAD.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   hdr_data/count/dest/drop/last header descriptor, handshaked with hdr_valid/hdr_ready
//   s_axis_*                      payload stream following the header (wire byte order)
//   m_axis_*                      emitted packet stream, tdest constant per packet
module meta_deparser_emitter #(
    parameter int AXIS_DATA_WIDTH     = 64,
    parameter int AXIS_KEEP_WIDTH     = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_DEST_WIDTH     = 2,
    parameter int COUNT_META_DATA_MAX = 5,
    parameter int COUNTER_WIDTH       = $clog2(COUNT_META_DATA_MAX + 1),
    parameter int BUFFER_DATA_WIDTH   = COUNT_META_DATA_MAX * AXIS_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUFFER_DATA_WIDTH-1:0] hdr_data,
    input  logic [COUNTER_WIDTH-1:0]     hdr_count,
    input  logic [AXIS_DEST_WIDTH-1:0]   hdr_dest,
    input  logic                         hdr_drop,
    input  logic                         hdr_last,
    input  logic                         hdr_valid,
    output logic                         hdr_ready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [AXIS_DEST_WIDTH-1:0]   m_axis_tdest
);

    localparam int W  = AXIS_DATA_WIDTH;
    localparam int NB = AXIS_KEEP_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] MAX_C = COUNTER_WIDTH'(COUNT_META_DATA_MAX);

    typedef enum logic [1:0] {IDLE, SEND_HEADER, SEND_PAYLOAD, DROP} state_t;

    // Latched descriptor; count is stored as the index of the final header beat.
    typedef struct packed {
        logic [BUFFER_DATA_WIDTH-1:0] data;
        logic [COUNTER_WIDTH-1:0]     last_idx;
        logic [AXIS_DEST_WIDTH-1:0]   dest;
        logic                         last;
    } hdr_t;

    state_t                   state;
    hdr_t                     hdr_q;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic [COUNTER_WIDTH-1:0] last_idx_in;
    logic [W-1:0]             cur_beat;
    logic                     out_en;
    logic                     final_hdr_beat;

    function automatic logic [W-1:0] reverse_bytes(input logic [W-1:0] beat);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[i*8 +: 8] = beat[(NB-1-i)*8 +: 8];
        end
        return r;
    endfunction

    // A count of zero still emits one beat; oversize counts clamp to the buffer depth.
    always_comb begin
        last_idx_in = '0;
        if (hdr_count == '0) begin
            last_idx_in = '0;
        end else if (hdr_count > MAX_C) begin
            last_idx_in = MAX_C - 1'b1;
        end else begin
            last_idx_in = hdr_count - 1'b1;
        end
    end

    // Beat 0 sits in the MSBs of the buffer.
    always_comb begin
        cur_beat = '0;
        for (int k = 0; k < COUNT_META_DATA_MAX; k++) begin
            if (cnt == COUNTER_WIDTH'(k)) begin
                cur_beat = hdr_q.data[BUFFER_DATA_WIDTH-1-k*W -: W];
            end
        end
    end

    assign out_en         = !m_axis_tvalid || m_axis_tready;
    assign final_hdr_beat = (cnt == hdr_q.last_idx);
    assign hdr_ready      = !rst && (state == IDLE);
    assign s_axis_tready  = !rst && ((state == SEND_PAYLOAD && out_en) || state == DROP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            hdr_q         <= '0;
            cnt           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdest  <= '0;
        end else begin
            // A consumed beat retires unless a new one is loaded below; this also
            // drains the previous packet's final beat while in IDLE or DROP.
            if (out_en) begin
                m_axis_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (hdr_valid) begin
                        hdr_q.data     <= hdr_data;
                        hdr_q.last_idx <= last_idx_in;
                        hdr_q.dest     <= hdr_dest;
                        hdr_q.last     <= hdr_last;
                        cnt            <= '0;
                        state          <= hdr_drop ? DROP : SEND_HEADER;
                    end
                end
                SEND_HEADER: begin
                    if (out_en) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= reverse_bytes(cur_beat);
                        m_axis_tkeep  <= '1;
                        m_axis_tlast  <= final_hdr_beat && hdr_q.last;
                        m_axis_tdest  <= hdr_q.dest;
                        cnt           <= cnt + 1'b1;
                        if (final_hdr_beat) begin
                            state <= hdr_q.last ? IDLE : SEND_PAYLOAD;
                        end
                    end
                end
                SEND_PAYLOAD: begin
                    if (out_en && s_axis_tvalid) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tkeep  <= s_axis_tkeep;
                        m_axis_tlast  <= s_axis_tlast;
                        m_axis_tdest  <= hdr_q.dest;
                        if (s_axis_tlast) begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meta_deparser_emitter.sv
module tb_meta_deparser_emitter;

    localparam int W   = 64;
    localparam int NB  = 8;
    localparam int DW  = 2;
    localparam int MAX = 5;
    localparam int CW  = 3;
    localparam int BDW = MAX * W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [BDW-1:0] hdr_data = '0;
    logic [CW-1:0]  hdr_count = '0;
    logic [DW-1:0]  hdr_dest = '0;
    logic           hdr_drop = 1'b0;
    logic           hdr_last = 1'b0;
    logic           hdr_valid = 1'b0;
    logic           hdr_ready;
    logic [W-1:0]   s_axis_tdata = '0;
    logic [NB-1:0]  s_axis_tkeep = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic           s_axis_tlast = 1'b0;
    logic [W-1:0]   m_axis_tdata;
    logic [NB-1:0]  m_axis_tkeep;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic           m_axis_tlast;
    logic [DW-1:0]  m_axis_tdest;

    meta_deparser_emitter dut (
        .clk(clk), .rst(rst),
        .hdr_data(hdr_data), .hdr_count(hdr_count), .hdr_dest(hdr_dest),
        .hdr_drop(hdr_drop), .hdr_last(hdr_last), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [NB-1:0] k;
        logic          l;
        logic [DW-1:0] dst;
    } beat_t;

    typedef struct {
        logic [CW-1:0] count;
        logic          last;
        logic          drop;
        logic [DW-1:0] dest;
        int            npay;
        bit            stall;
        int            exp_beats;
    } vec_t;

    beat_t sb[$];
    int    hs_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    stall_en = 1'b0;
    bit    hold_rdy = 1'b0;
    bit    stalled = 1'b0;
    beat_t held;
    beat_t cur;
    beat_t expb;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (hold_rdy) m_axis_tready = 1'b0;
        else if (stall_en) m_axis_tready = 1'($urandom_range(0, 1));
        else m_axis_tready = 1'b1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = x[8*(NB-1-i) +: 8];
        return r;
    endfunction

    // Output monitor: samples after the negedge drives have settled.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest};
            if (stalled) begin
                chk("stall_hold_vld", {127'd0, m_axis_tvalid}, 128'd1);
                chk("stall_hold_beat", cur, held);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_beat", cur, 128'd0 - 1);
                end else begin
                    expb = sb.pop_front();
                    chk("out_beat", cur, expb);
                end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held = cur;
        end
    end

    task automatic send_desc(input logic [BDW-1:0] data, input logic [CW-1:0] count,
                             input logic last, input logic drop, input logic [DW-1:0] dest,
                             input bit push);
        int t;
        int eff;
        eff = (count == 0) ? 1 : int'(count);
        t = 0;
        @(negedge clk);
        while (!hdr_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!hdr_ready) chk("hdr_ready_timeout", 128'd0, 128'd1);
        hdr_data = data; hdr_count = count; hdr_last = last; hdr_drop = drop;
        hdr_dest = dest; hdr_valid = 1'b1;
        if (push && !drop) begin
            for (int k = 0; k < eff; k++)
                sb.push_back({rev(data[BDW-1-k*W -: W]), 8'hFF, last && (k == eff-1), dest});
        end
        @(posedge clk);
        #1;
        hdr_valid = 1'b0;
    endtask

    task automatic send_payload(input int n, input logic [DW-1:0] dest, input logic drop,
                                input bit end_last, output int waits);
        int t;
        waits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tlast  = end_last && (i == n-1);
            s_axis_tkeep  = s_axis_tlast ? NB'($urandom_range(1, 255)) : 8'hFF;
            s_axis_tvalid = 1'b1;
            #1;
            t = 0;
            while (!s_axis_tready && t < 300) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (!s_axis_tready) chk("s_tready_timeout", 128'd0, 128'd1);
            waits += t;
            if (!drop) sb.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tlast, dest});
            @(posedge clk);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_timeout", 128'(sb.size()), 128'd0);
    endtask

    function automatic logic [BDW-1:0] rand_hdr();
        logic [BDW-1:0] d;
        for (int i = 0; i < BDW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    vec_t vecs[5];
    int   waits;
    int   nhs;
    int   sr_bad;
    int   c0;
    logic [BDW-1:0] d1;

    initial begin
        vecs[0] = '{count: 3'd3, last: 1'b1, drop: 1'b0, dest: 2'd1, npay: 0, stall: 1'b0, exp_beats: 3};
        vecs[1] = '{count: 3'd1, last: 1'b0, drop: 1'b1, dest: 2'd2, npay: 4, stall: 1'b0, exp_beats: 0};
        vecs[2] = '{count: 3'd5, last: 1'b0, drop: 1'b0, dest: 2'd3, npay: 3, stall: 1'b1, exp_beats: 8};
        vecs[3] = '{count: 3'd0, last: 1'b1, drop: 1'b0, dest: 2'd2, npay: 0, stall: 1'b0, exp_beats: 1};
        vecs[4] = '{count: 3'd2, last: 1'b0, drop: 1'b0, dest: 2'd0, npay: 2, stall: 1'b1, exp_beats: 4};

        // Reset state
        #12;
        chk("rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
        chk("rst_tdata_keep", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest}, 128'd0);
        chk("rst_hdr_ready", {127'd0, hdr_ready}, 128'd0);
        chk("rst_s_tready", {127'd0, s_axis_tready}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_hdr_ready", {127'd0, hdr_ready}, 128'd1);

        // Two header beats, one payload beat, first beat one cycle after accept.
        d1 = {64'h0011223344556677, 64'h8899AABBCCDDEEFF, 192'd0};
        sb.push_back({64'h7766554433221100, 8'hFF, 1'b0, 2'd2});
        sb.push_back({64'hFFEEDDCCBBAA9988, 8'hFF, 1'b0, 2'd2});
        send_desc(d1, 3'd2, 1'b0, 1'b0, 2'd2, 1'b0);
        chk("lat_vld_at_accept", {127'd0, m_axis_tvalid}, 128'd0);
        @(posedge clk);
        #1;
        chk("lat_vld_next_cycle", {127'd0, m_axis_tvalid}, 128'd1);
        chk("lat_first_data", m_axis_tdata, 64'h7766554433221100);
        send_payload(1, 2'd2, 1'b0, 1'b1, waits);
        wait_drain();

        // Table-driven packets
        for (int v = 0; v < 5; v++) begin
            stall_en = vecs[v].stall;
            nhs = hs_cyc.size();
            send_desc(rand_hdr(), vecs[v].count, vecs[v].last, vecs[v].drop, vecs[v].dest, 1'b1);
            if (vecs[v].npay == 0) begin
                sr_bad = 0;
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    #1;
                    if (s_axis_tready) sr_bad++;
                end
                chk($sformatf("vec%0d_s_tready_low", v), 128'(sr_bad), 128'd0);
            end else begin
                send_payload(vecs[v].npay, vecs[v].dest, vecs[v].drop, 1'b1, waits);
                if (vecs[v].drop) chk($sformatf("vec%0d_drop_waits", v), 128'(waits), 128'd0);
            end
            wait_drain();
            chk($sformatf("vec%0d_beats", v), 128'(hs_cyc.size() - nhs), 128'(vecs[v].exp_beats));
            stall_en = 1'b0;
        end
        #1;
        chk("drop_back_to_idle", {127'd0, hdr_ready}, 128'd1);

        // Back-to-back descriptors: one bubble for the accept, tdest switches on packet 2.
        nhs = hs_cyc.size();
        send_desc(rand_hdr(), 3'd2, 1'b1, 1'b0, 2'd1, 1'b1);
        send_desc(rand_hdr(), 3'd2, 1'b1, 1'b0, 2'd2, 1'b1);
        wait_drain();
        chk("b2b_beats", 128'(hs_cyc.size() - nhs), 128'd4);
        if (hs_cyc.size() - nhs == 4) begin
            c0 = hs_cyc[nhs];
            chk("b2b_gap_a", 128'(hs_cyc[nhs+1] - c0), 128'd1);
            chk("b2b_gap_ab", 128'(hs_cyc[nhs+2] - c0), 128'd3);
            chk("b2b_gap_b", 128'(hs_cyc[nhs+3] - c0), 128'd4);
        end

        // Reset while in SEND_PAYLOAD with a stalled beat in the output register.
        send_desc(rand_hdr(), 3'd1, 1'b0, 1'b0, 2'd3, 1'b1);
        send_payload(1, 2'd3, 1'b0, 1'b0, waits);
        wait_drain();
        hold_rdy = 1'b1;
        send_payload(1, 2'd3, 1'b0, 1'b0, waits);
        chk("pre_rst_vld", {127'd0, m_axis_tvalid}, 128'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("midpkt_rst_vld", {127'd0, m_axis_tvalid}, 128'd0);
        chk("midpkt_rst_s_tready", {127'd0, s_axis_tready}, 128'd0);
        sb.delete();
        @(negedge clk);
        hold_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_vld", {127'd0, m_axis_tvalid}, 128'd0);
        chk("post_rst_hdr_ready", {127'd0, hdr_ready}, 128'd1);
        nhs = hs_cyc.size();
        send_desc(rand_hdr(), 3'd3, 1'b0, 1'b0, 2'd1, 1'b1);
        send_payload(2, 2'd1, 1'b0, 1'b1, waits);
        wait_drain();
        chk("post_rst_beats", 128'(hs_cyc.size() - nhs), 128'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
